// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008/MCP3004 SPI responder.
// Holds the FSM encoding and the differential-result helper.
package mcp3008_pkg;

   localparam int CMD_BITS    = 4;   // SGL, D2, D1, D0
   localparam int RESULT_BITS = 10;
   localparam int NULL_BITS   = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_CMD,
      ST_SAMPLE,
      ST_NULL,
      ST_DATA,
      ST_TAIL
   } state_t;

   // IN+ minus IN-, floored at zero; the 11-bit signed intermediate cannot overflow.
   function automatic logic [RESULT_BITS-1:0] diff_clamp(
      input logic [RESULT_BITS-1:0] in_p,
      input logic [RESULT_BITS-1:0] in_m
   );
      logic signed [RESULT_BITS:0] diff;
      diff = $signed({1'b0, in_p}) - $signed({1'b0, in_m});
      return diff[RESULT_BITS] ? '0 : diff[RESULT_BITS-1:0];
   endfunction

endpackage

// File: rtl/mcp3008_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with one-clk rise/fall
// pulses derived from the synchronized level.
module mcp3008_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the chain into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise =  q & ~prev_q;
   assign fall = ~q &  prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008/MCP3004 ADC emulator: decodes the SPI command and shifts back the
// addressed channel value. Define MCP3008_LSB_REPEAT_EN for the LSB-first echo.
module mcp3008_responder
   import mcp3008_pkg::*;
#(
   parameter int NUM_CHANNELS = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                dclk,
   input  logic                                cs_n,
   input  logic                                din,
   output logic                                dout,
   output logic                                dout_oe,
   input  logic [NUM_CHANNELS*RESULT_BITS-1:0] ch_data,
   output logic                                conv_strobe,
   output logic [2:0]                          conv_ch,
   output logic                                conv_sgl
);

   localparam int   CH_W   = $clog2(NUM_CHANNELS);
   localparam logic D2_EN  = (NUM_CHANNELS == 8);
   localparam logic [3:0] LAST_CMD = 4'(CMD_BITS - 1);
   localparam logic [3:0] MSB_IDX  = 4'(RESULT_BITS - 1);

   logic dclk_s, dclk_rise, dclk_fall;
   logic cs_s, cs_unused_rise, cs_unused_fall;
   logic din_s, din_unused_rise, din_unused_fall;

   mcp3008_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dclk (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (dclk),
      .q    (dclk_s),
      .rise (dclk_rise),
      .fall (dclk_fall)
   );

   mcp3008_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (cs_n),
      .q    (cs_s),
      .rise (cs_unused_rise),
      .fall (cs_unused_fall)
   );

   mcp3008_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (din),
      .q    (din_s),
      .rise (din_unused_rise),
      .fall (din_unused_fall)
   );

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [CMD_BITS-1:0]    cmd_q, cmd_d;
   logic [RESULT_BITS-1:0] result_q, result_d;
   logic                   dout_q, dout_d;
   logic                   oe_q, oe_d;
   logic                   strobe_q, strobe_d;
   logic [2:0]             conv_ch_q, conv_ch_d;
   logic                   conv_sgl_q, conv_sgl_d;

   // Result selection from the captured command and the live channel inputs.
   logic [RESULT_BITS-1:0] chan [NUM_CHANNELS];
   logic [2:0]             ch_sel;
   logic [CH_W-1:0]        idx_se, idx_a, idx_b;
   logic [RESULT_BITS-1:0] in_a, in_b, sample_result;

   always_comb begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         chan[k] = ch_data[k*RESULT_BITS +: RESULT_BITS];
      end
   end

   always_comb begin
      ch_sel = {cmd_q[2] & D2_EN, cmd_q[1:0]};
      idx_se = CH_W'(ch_sel);
      idx_a  = CH_W'({ch_sel[2:1], 1'b0});
      idx_b  = CH_W'({ch_sel[2:1], 1'b1});
      in_a   = chan[idx_a];
      in_b   = chan[idx_b];
      if (cmd_q[3]) begin
         sample_result = chan[idx_se];
      end else if (cmd_q[0]) begin
         sample_result = diff_clamp(in_b, in_a);
      end else begin
         sample_result = diff_clamp(in_a, in_b);
      end
   end

   // NOTE: every variable gets its hold value before the case statement, so
   // branches that leave one untouched cannot infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      result_d   = result_q;
      dout_d     = dout_q;
      oe_d       = oe_q;
      strobe_d   = 1'b0;
      conv_ch_d  = conv_ch_q;
      conv_sgl_d = conv_sgl_q;

      if (cs_s) begin
         state_d = ST_IDLE;
         dout_d  = 1'b0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_WAIT_START;

            ST_WAIT_START: begin
               if (dclk_rise && din_s) begin
                  state_d = ST_CMD;
                  cnt_d   = '0;
               end
            end

            ST_CMD: begin
               if (dclk_rise) begin
                  cmd_d = {cmd_q[CMD_BITS-2:0], din_s};
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == LAST_CMD) state_d = ST_SAMPLE;
               end
            end

            ST_SAMPLE: begin
               if (dclk_fall) begin
                  result_d   = sample_result;
                  strobe_d   = 1'b1;
                  conv_ch_d  = ch_sel;
                  conv_sgl_d = cmd_q[3];
                  state_d    = ST_NULL;
               end
            end

            ST_NULL: begin
               if (dclk_fall) begin
                  dout_d  = 1'b0;
                  oe_d    = 1'b1;
                  cnt_d   = MSB_IDX;
                  state_d = ST_DATA;
               end
            end

            ST_DATA: begin
               if (dclk_fall) begin
                  dout_d = result_q[cnt_q];
                  if (cnt_q == 4'd0) begin
                     cnt_d   = 4'd1;   // first echo index when the echo is built in
                     state_d = ST_TAIL;
                  end else begin
                     cnt_d = cnt_q - 4'd1;
                  end
               end
            end

            ST_TAIL: begin
               if (dclk_fall) begin
`ifdef MCP3008_LSB_REPEAT_EN
                  // cnt walks 1..9 for the echo, then parks at 0 for zeros.
                  if (cnt_q != 4'd0) begin
                     dout_d = result_q[cnt_q];
                     cnt_d  = (cnt_q == MSB_IDX) ? 4'd0 : cnt_q + 4'd1;
                  end else begin
                     dout_d = 1'b0;
                  end
`else
                  dout_d = 1'b0;
`endif
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: the result word is reset along with the control flops; it is a
   // single register, not a memory array, so the reset costs nothing extra.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cmd_q      <= '0;
         result_q   <= '0;
         dout_q     <= 1'b0;
         oe_q       <= 1'b0;
         strobe_q   <= 1'b0;
         conv_ch_q  <= '0;
         conv_sgl_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         result_q   <= result_d;
         dout_q     <= dout_d;
         oe_q       <= oe_d;
         strobe_q   <= strobe_d;
         conv_ch_q  <= conv_ch_d;
         conv_sgl_q <= conv_sgl_d;
      end
   end

   assign dout        = dout_q;
   assign dout_oe     = oe_q;
   assign conv_strobe = strobe_q;
   assign conv_ch     = conv_ch_q;
   assign conv_sgl    = conv_sgl_q;

   // dclk level itself is only consumed through its edge pulses.
   logic dclk_unused_level;
   assign dclk_unused_level = dclk_s;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: an 8-channel and a 4-channel instance
// share one SPI bus driven by tasks that act as the initiator.
module tb_mcp3008_responder;

   localparam int HALF = 8;   // clk cycles per dclk half period
   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        din = 1'b0;
   logic [79:0] ch_data = '0;
   logic [39:0] ch_data4 = '0;

   logic       dout, dout_oe, conv_strobe, conv_sgl;
   logic [2:0] conv_ch;
   logic       dout4, dout_oe4, conv_strobe4, conv_sgl4;
   logic [2:0] conv_ch4;

   mcp3008_responder #(.NUM_CHANNELS(8), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .dclk(dclk), .cs_n(cs_n), .din(din),
      .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data),
      .conv_strobe(conv_strobe), .conv_ch(conv_ch), .conv_sgl(conv_sgl)
   );

   mcp3008_responder #(.NUM_CHANNELS(4), .SYNC_STAGES(SYNC)) dut4 (
      .clk(clk), .rst_n(rst_n), .dclk(dclk), .cs_n(cs_n), .din(din),
      .dout(dout4), .dout_oe(dout_oe4), .ch_data(ch_data4),
      .conv_strobe(conv_strobe4), .conv_ch(conv_ch4), .conv_sgl(conv_sgl4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;
   int strobe4_cnt = 0;

   always @(posedge clk) begin
      if (conv_strobe === 1'b1) strobe_cnt++;
      if (conv_strobe4 === 1'b1) strobe4_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [79:0] mk8(input logic [9:0] c0, input logic [9:0] c1,
                                       input logic [9:0] c2, input logic [9:0] c3,
                                       input logic [9:0] c4, input logic [9:0] c5,
                                       input logic [9:0] c6, input logic [9:0] c7);
      return {c7, c6, c5, c4, c3, c2, c1, c0};
   endfunction

   // Values seen on the bus just before the most recent dclk rise.
   logic s_dout, s_dout4, s_oe;

   task automatic dclk_cycle(input logic b);
      din = b;
      repeat (HALF) @(posedge clk);
      #1;
      s_dout  = dout;
      s_dout4 = dout4;
      s_oe    = dout_oe;
      dclk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      dclk = 1'b0;
   endtask

   task automatic spi_xfer(input int lead, input logic sgl, input logic [2:0] d, input int extra,
                           output logic [9:0] res, output logic [9:0] res4,
                           output logic nullb, output logic oe_wait, output logic oe_null,
                           output logic [31:0] tail);
      logic [4:0] cmd;
      logic       rx [64];
      logic       rx4 [64];
      logic       oe [64];
      int         n;
      cmd = {1'b1, sgl, d};
      n   = lead + 17 + extra;
      cs_n = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         dclk_cycle((i >= lead && i < lead + 5) ? cmd[4 - (i - lead)] : 1'b0);
         rx[i]  = s_dout;
         rx4[i] = s_dout4;
         oe[i]  = s_oe;
      end
      din = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      cs_n = 1'b1;
      repeat (2 * HALF) @(posedge clk);
      #1;
      for (int b = 0; b < 10; b++) begin
         res[9 - b]  = rx[lead + 7 + b];
         res4[9 - b] = rx4[lead + 7 + b];
      end
      nullb   = rx[lead + 6];
      oe_wait = oe[lead + 5];
      oe_null = oe[lead + 6];
      tail    = '0;
      for (int j = 0; j < extra && j < 32; j++) tail[j] = rx[lead + 17 + j];
   endtask

   typedef struct {
      string       name;
      logic [79:0] chd;
      int          lead;
      logic        sgl;
      logic [2:0]  d;
      logic [9:0]  exp_res;
      logic [2:0]  exp_ch;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [9:0]  res, res4;
      logic        nullb, oe_wait, oe_null;
      logic [31:0] tail, exp_tail;
      int          s0, s40;

      vecs[0] = '{"se_ch5", mk8(10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h2A5, 10'h066, 10'h077),
                  0, 1'b1, 3'd5, 10'h2A5, 3'd5};
      vecs[1] = '{"diff_010", mk8(10'd0, 10'd0, 10'd700, 10'd200, 10'd0, 10'd0, 10'd0, 10'd0),
                  0, 1'b0, 3'd2, 10'd500, 3'd2};
      vecs[2] = '{"diff_011", mk8(10'd0, 10'd0, 10'd700, 10'd200, 10'd0, 10'd0, 10'd0, 10'd0),
                  0, 1'b0, 3'd3, 10'd0, 3'd3};
      vecs[3] = '{"lead_zero", mk8(10'h155, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF),
                  3, 1'b1, 3'd0, 10'h155, 3'd0};
      vecs[4] = '{"diff_101", mk8(10'd0, 10'd0, 10'd0, 10'd0, 10'd100, 10'd900, 10'd0, 10'd0),
                  0, 1'b0, 3'd5, 10'd800, 3'd5};
      vecs[5] = '{"diff_equal", mk8(10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd512, 10'd512),
                  0, 1'b0, 3'd6, 10'd0, 3'd6};
      vecs[6] = '{"diff_full", mk8(10'd1023, 10'd0, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8),
                  0, 1'b0, 3'd0, 10'd1023, 3'd0};

      ch_data4 = {10'h1C7, 10'd300, 10'd20, 10'd5};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_oe", 32'(dout_oe), 32'd0);
      check("rst_strobe", 32'(conv_strobe), 32'd0);
      check("rst_ch", 32'(conv_ch), 32'd0);
      check("rst_sgl", 32'(conv_sgl), 32'd0);

      // Table-driven single transactions
      for (int v = 0; v < 7; v++) begin
         ch_data = vecs[v].chd;
         s0 = strobe_cnt;
         spi_xfer(vecs[v].lead, vecs[v].sgl, vecs[v].d, 0, res, res4, nullb, oe_wait, oe_null, tail);
         check($sformatf("%s_res", vecs[v].name), 32'(res), 32'(vecs[v].exp_res));
         check($sformatf("%s_null", vecs[v].name), 32'(nullb), 32'd0);
         check($sformatf("%s_oe_wait", vecs[v].name), 32'(oe_wait), 32'd0);
         check($sformatf("%s_oe_null", vecs[v].name), 32'(oe_null), 32'd1);
         check($sformatf("%s_strobes", vecs[v].name), 32'(strobe_cnt - s0), 32'd1);
         check($sformatf("%s_ch", vecs[v].name), 32'(conv_ch), 32'(vecs[v].exp_ch));
         check($sformatf("%s_sgl", vecs[v].name), 32'(conv_sgl), 32'(vecs[v].sgl));
      end

      // Abort after the second command bit: no conversion, outputs quiet
      ch_data = mk8(10'd1, 10'd2, 10'd3, 10'h3FF, 10'd5, 10'd6, 10'd7, 10'h3FF);
      s0 = strobe_cnt;
      cs_n = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      dclk_cycle(1'b1);
      dclk_cycle(1'b1);
      dclk_cycle(1'b1);
      cs_n = 1'b1;
      repeat (SYNC + 2) @(posedge clk);
      #1;
      check("abort_cmd_oe", 32'(dout_oe), 32'd0);
      repeat (2 * HALF) @(posedge clk);
      #1;
      check("abort_cmd_strobes", 32'(strobe_cnt - s0), 32'd0);
      check("abort_cmd_ch_held", 32'(conv_ch), 32'd0);

      // Abort mid-data on ch3 = 0x3FF: driver released within SYNC+2 clk
      s0 = strobe_cnt;
      cs_n = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      dclk_cycle(1'b1);
      dclk_cycle(1'b1);
      dclk_cycle(1'b0);
      dclk_cycle(1'b1);
      dclk_cycle(1'b1);
      for (int i = 0; i < 5; i++) dclk_cycle(1'b0);
      repeat (SYNC + 2) @(posedge clk);
      #1;
      check("abort_data_oe_on", 32'(dout_oe), 32'd1);
      check("abort_data_dout_on", 32'(dout), 32'd1);
      cs_n = 1'b1;
      repeat (SYNC + 2) @(posedge clk);
      #1;
      check("abort_data_oe_off", 32'(dout_oe), 32'd0);
      check("abort_data_dout_off", 32'(dout), 32'd0);
      check("abort_data_strobes", 32'(strobe_cnt - s0), 32'd1);
      repeat (2 * HALF) @(posedge clk);
      #1;

      // Full transaction after the aborts
      spi_xfer(0, 1'b1, 3'd7, 0, res, res4, nullb, oe_wait, oe_null, tail);
      check("post_abort_ch7", 32'(res), 32'h3FF);
      check("post_abort_conv_ch", 32'(conv_ch), 32'd7);

      // 4-channel part: D2 is masked
      s40 = strobe4_cnt;
      spi_xfer(0, 1'b1, 3'd7, 0, res, res4, nullb, oe_wait, oe_null, tail);
      check("mcp3004_se_res", 32'(res4), 32'h1C7);
      check("mcp3004_se_ch", 32'(conv_ch4), 32'd3);
      check("mcp3004_se_sgl", 32'(conv_sgl4), 32'd1);
      check("mcp3004_strobes", 32'(strobe4_cnt - s40), 32'd1);
      spi_xfer(0, 1'b0, 3'd7, 0, res, res4, nullb, oe_wait, oe_null, tail);
      check("mcp3004_diff_res", 32'(res4), 32'd155);
      check("mcp3004_diff_ch", 32'(conv_ch4), 32'd3);

      // Back-to-back on ch0/ch1/ch2, last one with 17 trailing dclks
      ch_data = mk8(10'h0F0, 10'h30C, 10'h1A7, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
      s0 = strobe_cnt;
      spi_xfer(0, 1'b1, 3'd0, 0, res, res4, nullb, oe_wait, oe_null, tail);
      check("b2b_ch0", 32'(res), 32'h0F0);
      spi_xfer(0, 1'b1, 3'd1, 0, res, res4, nullb, oe_wait, oe_null, tail);
      check("b2b_ch1", 32'(res), 32'h30C);
      spi_xfer(0, 1'b1, 3'd2, 17, res, res4, nullb, oe_wait, oe_null, tail);
      check("b2b_ch2", 32'(res), 32'h1A7);
      check("b2b_strobes", 32'(strobe_cnt - s0), 32'd3);
      exp_tail = '0;
`ifdef MCP3008_LSB_REPEAT_EN
      begin
         logic [9:0] ch2_val;
         ch2_val = 10'h1A7;
         for (int j = 0; j < 9; j++) exp_tail[j] = ch2_val[j + 1];
      end
`endif
      check("b2b_tail", tail, exp_tail);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case a task never returns.
   initial begin
      #2_000_000;
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1);
   end

endmodule
